// File: rtl/seg_display_reader.sv
// seg_display_reader: decodes a multiplexed 4-digit 7-segment scan back into a
// signed value. Each digit dwell is debounced and captured once, the scan
// order is tracked by a small FSM, and a complete frame is composed into a
// signed result with a one-cycle valid pulse.
module seg_display_reader #(
  parameter int unsigned ANODE_WIDTH   = 4,
  parameter int unsigned SEGMENT_WIDTH = 7,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned VALUE_WIDTH   = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ANODE_WIDTH-1:0]   anode_i,
  input  logic [SEGMENT_WIDTH-1:0] seg_i,
  output logic [VALUE_WIDTH-1:0]   value_o,
  output logic                     value_valid_o,
  output logic                     is_error_o,
  output logic                     scan_error_o,
  output logic                     bad_glyph_o
);

  localparam int unsigned SlotW = (ANODE_WIDTH > 1) ? $clog2(ANODE_WIDTH) : 1;

  // Internal glyph codes: 0..9 are digits, the rest are markers.
  localparam logic [3:0] CodeMinus = 4'hA;
  localparam logic [3:0] CodeE     = 4'hE;
  localparam logic [3:0] CodeBad   = 4'hF;

  typedef enum logic [1:0] {StSync, StCollect, StEmit} state_e;

  function automatic logic [3:0] decode_glyph(input logic [SEGMENT_WIDTH-1:0] s);
    logic [3:0] code;
    case (s)
      7'b1111110: code = 4'd0;
      7'b0110000: code = 4'd1;
      7'b1101101: code = 4'd2;
      7'b1111001: code = 4'd3;
      7'b0110011: code = 4'd4;
      7'b1011011: code = 4'd5;
      7'b1011111: code = 4'd6;
      7'b1110000: code = 4'd7;
      7'b1111111: code = 4'd8;
      7'b1111011: code = 4'd9;
      7'b1001111: code = CodeE;
      7'b0000001: code = CodeMinus;
      default:    code = CodeBad;
    endcase
    return code;
  endfunction

  // Sampled inputs and settle tracking
  logic [ANODE_WIDTH-1:0]   anode_q;
  logic [SEGMENT_WIDTH-1:0] seg_q;
  logic [7:0]               cnt_q, cnt_d;
  logic                     captured_q, captured_d;

  // Frame state
  state_e                   state_q;
  logic [SlotW-1:0]         expect_q;
  logic [3:0]               d0_q, d1_q, d2_q;
  logic                     neg_q;

  // Registered outputs
  logic [VALUE_WIDTH-1:0]   value_q;
  logic                     valid_q, is_error_q, scan_q, bad_q;

  // Combinational helpers
  logic                     pair_match, dwell_event;
  logic [ANODE_WIDTH-1:0]   anode_minus1;
  logic                     multi_hot, one_hot;
  logic [SlotW-1:0]         slot;
  logic [3:0]               glyph;
  logic                     is_digit, legal;
  logic                     cap_ok, cap_bad, multi_ev;
  logic [VALUE_WIDTH-1:0]   mag, signed_val;
  logic                     err_frame, err_bad;

  // Settle counter, anode classification, glyph legality per slot
  always_comb begin
    pair_match = (anode_i == anode_q) && (seg_i == seg_q);
    if (!pair_match) begin
      cnt_d = '0;
    end else if (cnt_q >= 8'(SETTLE_CYCLES)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    // cnt_d only equals SETTLE_CYCLES (>= 1) while the pair is held
    dwell_event = (cnt_d == 8'(SETTLE_CYCLES)) && !captured_q;

    anode_minus1 = anode_i - ANODE_WIDTH'(1);
    multi_hot    = |(anode_i & anode_minus1);
    one_hot      = (anode_i != '0) && !multi_hot;

    slot = '0;
    for (int unsigned i = 0; i < ANODE_WIDTH; i++) begin
      if (anode_i[i]) slot = SlotW'(i);
    end

    glyph    = decode_glyph(seg_i);
    is_digit = (glyph <= 4'd9);
    case (int'(slot))
      0:       legal = is_digit || (glyph == CodeE);
      1, 2:    legal = is_digit;
      3:       legal = (glyph == 4'd0) || (glyph == CodeMinus);
      default: legal = 1'b0;
    endcase

    cap_ok   = dwell_event && one_hot && legal;
    cap_bad  = dwell_event && one_hot && !legal;
    multi_ev = dwell_event && multi_hot;

    // One capture per dwell; a new anode value re-arms the capture
    if (anode_i != anode_q) begin
      captured_d = 1'b0;
    end else if (dwell_event && (anode_i != '0)) begin
      captured_d = 1'b1;
    end else begin
      captured_d = captured_q;
    end
  end

  // Frame composition from the captured slots
  always_comb begin
    mag = VALUE_WIDTH'(d2_q) * VALUE_WIDTH'(100)
        + VALUE_WIDTH'(d1_q) * VALUE_WIDTH'(10)
        + VALUE_WIDTH'(d0_q);
    // Two's complement negate; -0 naturally yields 0
    signed_val = neg_q ? (~mag + VALUE_WIDTH'(1)) : mag;
    err_frame  = (d0_q == CodeE) && (d1_q == 4'd0) && (d2_q == 4'd0) && !neg_q;
    err_bad    = (d0_q == CodeE) && !err_frame;
  end

  // Sampling, slot capture, frame FSM and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      anode_q    <= '0;
      seg_q      <= '0;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      state_q    <= StSync;
      expect_q   <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      neg_q      <= 1'b0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      is_error_q <= 1'b0;
      scan_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      anode_q    <= anode_i;
      seg_q      <= seg_i;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      valid_q    <= 1'b0;
      scan_q     <= 1'b0;
      bad_q      <= 1'b0;

      if (cap_ok) begin
        case (int'(slot))
          0:       d0_q  <= glyph;
          1:       d1_q  <= glyph;
          2:       d2_q  <= glyph;
          default: neg_q <= (glyph == CodeMinus);
        endcase
      end

      case (state_q)
        StSync: begin
          if (cap_ok && (slot == '0)) begin
            state_q  <= StCollect;
            expect_q <= SlotW'(1);
          end
        end
        StCollect: begin
          if (cap_ok) begin
            if (slot == expect_q) begin
              if (expect_q == SlotW'(ANODE_WIDTH - 1)) begin
                state_q <= StEmit;
              end else begin
                expect_q <= expect_q + SlotW'(1);
              end
            end else begin
              scan_q <= 1'b1;
              // A units digit out of turn starts a new frame right away
              if (slot == '0) begin
                expect_q <= SlotW'(1);
              end else begin
                state_q <= StSync;
              end
            end
          end
        end
        StEmit: begin
          if (err_bad) begin
            bad_q <= 1'b1;
          end else begin
            valid_q    <= 1'b1;
            value_q    <= err_frame ? '0 : signed_val;
            is_error_q <= err_frame;
          end
          if (cap_ok && (slot == '0)) begin
            state_q  <= StCollect;
            expect_q <= SlotW'(1);
          end else begin
            state_q <= StSync;
          end
        end
        default: state_q <= StSync;
      endcase

      // Scan faults and illegal glyphs always abort the frame in progress
      if (multi_ev || cap_bad) state_q <= StSync;
      if (multi_ev) scan_q <= 1'b1;
      if (cap_bad)  bad_q  <= 1'b1;
    end
  end

  assign value_o       = value_q;
  assign value_valid_o = valid_q;
  assign is_error_o    = is_error_q;
  assign scan_error_o  = scan_q;
  assign bad_glyph_o   = bad_q;

endmodule
